// File: rtl/frame_config_writer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_config_writer
//  Description : Parses a sync/header/data bitstream into frame words and
//                writes each frame through a one-hot frame-latch strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_config_writer #(
    parameter int                         FrameBitsPerRow = 32,
    parameter int                         MaxFramesPerCol = 20,
    parameter int                         NumRows         = 4,
    parameter logic [FrameBitsPerRow-1:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    input  logic [FrameBitsPerRow-1:0]           s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 cfg_done,
    output logic                                 cfg_error
);

    localparam int                         c_cntW     = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int                         c_idxW     = 5;
    localparam int                         c_lastBit  = 31;
    localparam logic [c_cntW-1:0]          c_lastRow  = c_cntW'(NumRows - 1);
    localparam logic [MaxFramesPerCol-1:0] c_strobeOne = MaxFramesPerCol'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_STROBE = 2'd3
    } state_t;

    state_t                               r_state;
    logic [c_cntW-1:0]                    r_wordCnt;
    logic [c_idxW-1:0]                    r_frameIdx;
    logic                                 r_last;
    logic                                 r_discard;
    logic [NumRows*FrameBitsPerRow-1:0]   r_shadow;

    logic                                 w_xfer;
    logic                                 w_hdrInvalid;
    logic [NumRows*FrameBitsPerRow-1:0]   w_nextShadow;

    assign w_xfer       = s_valid && s_ready;
    assign w_hdrInvalid = (int'(s_data[c_idxW-1:0]) >= MaxFramesPerCol);

    // Shadow image with the incoming word merged in, so the final word can be
    // copied to FrameData on the same edge it is accepted.
    always_comb begin
        w_nextShadow = r_shadow;
        for (int r = 0; r < NumRows; r++) begin
            if (r_wordCnt == c_cntW'(r)) begin
                w_nextShadow[r*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_wordCnt   <= '0;
            r_frameIdx  <= '0;
            r_last      <= 1'b0;
            r_discard   <= 1'b0;
            r_shadow    <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_error   <= 1'b0;
        end else begin
            cfg_done    <= 1'b0;
            FrameStrobe <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && (s_data == SyncWord)) begin
                        r_state   <= ST_HEADER;
                        busy      <= 1'b1;
                        cfg_error <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    if (w_xfer) begin
                        r_frameIdx <= s_data[c_idxW-1:0];
                        r_last     <= s_data[c_lastBit];
                        r_discard  <= w_hdrInvalid;
                        if (w_hdrInvalid) begin
                            cfg_error <= 1'b1;
                        end
                        r_wordCnt <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_shadow <= w_nextShadow;
                        if (r_wordCnt == c_lastRow) begin
                            r_wordCnt <= '0;
                            if (!r_discard) begin
                                FrameData   <= w_nextShadow;
                                FrameStrobe <= c_strobeOne << r_frameIdx;
                                s_ready     <= 1'b0;
                                r_state     <= ST_STROBE;
                            end else if (r_last) begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_state <= ST_HEADER;
                            end
                        end else begin
                            r_wordCnt <= r_wordCnt + 1'b1;
                        end
                    end
                end
                ST_STROBE: begin
                    s_ready <= 1'b1;
                    if (r_last) begin
                        r_state  <= ST_IDLE;
                        busy     <= 1'b0;
                        cfg_done <= 1'b1;
                    end else begin
                        r_state <= ST_HEADER;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_config_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_config_writer
//  Description : Scoreboard bench for frame_config_writer with a word-level
//                reference model of the sync/header/data stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_config_writer;

    localparam int          NF   = 20;
    localparam int          NR   = 4;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic         CLK = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] FrameData;
    logic [19:0]  FrameStrobe;
    logic         busy;
    logic         cfg_done;
    logic         cfg_error;

    frame_config_writer dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .cfg_done    (cfg_done),
        .cfg_error   (cfg_error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: word-level stream interpretation
    typedef struct {
        int           idx;
        logic [127:0] data;
        int           at;
    } strobe_t;

    strobe_t      sq[$];
    int           dq[$];
    int           phase;      // 0 = awaiting sync, 1 = header, 2 = data
    int           wk;
    int           mIdx;
    bit           mLast, mDiscard, mErr, mStrobe;
    logic [31:0]  rows[NR];
    logic [127:0] mFrame;

    task automatic modelReset();
        phase = 0; wk = 0; mIdx = 0;
        mLast = 0; mDiscard = 0; mErr = 0; mStrobe = 0;
        mFrame = '0;
    endtask

    task automatic modelAccept(input logic [31:0] w, input int at);
        strobe_t e;
        if (phase == 0) begin
            if (w == SYNC) begin
                phase = 1;
                mErr  = 0;
            end
        end else if (phase == 1) begin
            mIdx     = int'(w[4:0]);
            mLast    = w[31];
            mDiscard = (mIdx >= NF);
            if (mDiscard) mErr = 1;
            wk    = 0;
            phase = 2;
        end else begin
            rows[wk] = w;
            wk++;
            if (wk == NR) begin
                if (mDiscard) begin
                    phase = mLast ? 0 : 1;
                end else begin
                    for (int r = 0; r < NR; r++) mFrame[r*32 +: 32] = rows[r];
                    e.idx  = mIdx;
                    e.data = mFrame;
                    e.at   = at;
                    sq.push_back(e);
                    if (mLast) dq.push_back(at + 1);
                    mStrobe = 1;
                end
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] w, output bit acc);
        bit expReady;
        @(negedge CLK);
        s_valid  = v;
        s_data   = w;
        expReady = !mStrobe;
        chk("s_ready", s_ready, expReady);
        chk("busy", busy, (phase != 0) || mStrobe);
        chk("cfg_error", cfg_error, mErr);
        chk("FrameData", FrameData, mFrame);
        acc = v && expReady;
        @(posedge CLK);
        #1;
        if (mStrobe) begin
            mStrobe = 0;
            phase   = mLast ? 0 : 1;
        end else if (acc) begin
            modelAccept(w, cyc);
        end
    endtask

    task automatic send(input logic [31:0] w, input int gapPct);
        bit acc = 0;
        int n   = 0;
        while (!acc && n < 50) begin
            if (int'($urandom_range(99)) < gapPct) cycle(1'b0, $urandom, acc);
            else                                   cycle(1'b1, w, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no acceptance of %0h expected acceptance", w);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, $urandom, acc);
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_FrameData"}, FrameData, '0);
        chk({tag, "_FrameStrobe"}, FrameStrobe, '0);
        chk({tag, "_cfg_done"}, cfg_done, 1'b0);
        chk({tag, "_cfg_error"}, cfg_error, 1'b0);
    endtask

    // Monitor: pops expected strobes / done pulses whenever the DUT presents one
    strobe_t    me;
    logic [19:0] oh;
    int          md;
    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            if (sq.size() == 0) begin
                checks++; errors++;
                $display("FAIL strobe_unexpected: got %0h expected none (cycle %0d)", FrameStrobe, cyc);
            end else begin
                me = sq.pop_front();
                oh = '0;
                oh[me.idx] = 1'b1;
                chk("FrameStrobe", FrameStrobe, oh);
                chk("strobe_data", FrameData, me.data);
                chk("strobe_cycle", cyc, me.at);
            end
        end else if (sq.size() != 0 && sq[0].at <= cyc) begin
            me = sq.pop_front();
            checks++; errors++;
            $display("FAIL strobe_missing: got 0 expected index %0d at cycle %0d", me.idx, me.at);
        end
        if (cfg_done) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                md = dq.pop_front();
                chk("done_cycle", cyc, md);
            end
        end else if (dq.size() != 0 && dq[0] <= cyc) begin
            md = dq.pop_front();
            checks++; errors++;
            $display("FAIL done_missing: got 0 expected pulse at cycle %0d", md);
        end
    end

    initial begin
        logic [31:0] w[NR];
        logic [31:0] junk;
        bit          acc;
        int          nf, idx;

        modelReset();
        resetn  = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkResetOutputs("reset");
        resetn = 1'b1;

        // Single last frame into index 3
        send(SYNC, 0);
        send(32'h8000_0003, 0);
        send(32'h1111_1111, 0);
        send(32'h2222_2222, 0);
        send(32'h3333_3333, 0);
        send(32'h4444_4444, 0);
        idle(3);
        chk("basic_frame", FrameData, 128'h44444444_33333333_22222222_11111111);

        // Two back-to-back frames, continuous valid
        send(SYNC, 0);
        send(32'h0000_0000, 0);
        for (int i = 0; i < NR; i++) send($urandom, 0);
        send(32'h8000_0013, 0);
        for (int i = 0; i < NR; i++) send($urandom, 0);
        idle(3);

        // Out-of-range headers, then error cleared by sync
        send(SYNC, 0);
        send(32'h0000_0014, 0);
        for (int i = 0; i < NR; i++) send($urandom, 0);
        send(32'h8000_0015, 0);
        for (int i = 0; i < NR; i++) send($urandom, 0);
        idle(2);
        chk("error_sticky", cfg_error, 1'b1);
        send(SYNC, 0);
        send(32'h8000_0001, 0);
        for (int i = 0; i < NR; i++) send($urandom, 0);
        idle(3);

        // Valid gaps inside the data phase
        for (int i = 0; i < NR; i++) w[i] = $urandom;
        send(SYNC, 0);
        send(32'h8000_0005, 0);
        cycle(1'b1, w[0], acc);
        cycle(1'b0, $urandom, acc);
        cycle(1'b0, $urandom, acc);
        cycle(1'b1, w[1], acc);
        cycle(1'b1, w[2], acc);
        cycle(1'b0, $urandom, acc);
        cycle(1'b1, w[3], acc);
        idle(3);
        chk("gapped_frame", FrameData, {w[3], w[2], w[1], w[0]});

        // Reset mid-frame, then data without sync is ignored
        send(SYNC, 0);
        send(32'h8000_0002, 0);
        send(32'hAAAA_0001, 0);
        send(32'hAAAA_0002, 0);
        @(negedge CLK);
        s_valid = 1'b0;
        resetn  = 1'b0;
        #1;
        checkResetOutputs("midreset");
        modelReset();
        @(negedge CLK);
        resetn = 1'b1;
        send(32'hAAAA_0003, 0);
        send(32'hAAAA_0004, 0);
        send(32'h8000_0002, 0);
        for (int i = 0; i < NR; i++) send(32'hBBBB_0000 + 32'(i), 0);
        idle(3);

        // Randomized streams
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 2)) begin
                junk = $urandom;
                if (junk == SYNC) junk = junk ^ 32'h1;
                send(junk, 25);
            end
            send(SYNC, 25);
            nf = int'($urandom_range(1, 4));
            for (int f = 0; f < nf; f++) begin
                idx = int'($urandom_range(0, 23));
                send({(f == nf - 1), 26'($urandom), 5'(idx)}, 25);
                for (int i = 0; i < NR; i++) begin
                    if ($urandom_range(7) == 0) send(SYNC, 25);
                    else                        send($urandom, 25);
                end
            end
            idle(int'($urandom_range(0, 2)));
        end

        idle(4);
        chk("strobe_queue_empty", sq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
